// File: rtl/dip_serializer_pkg.sv
// Shared definitions for the DIP/switch serial link transmitter.
package dip_serializer_pkg;

  localparam int unsigned COUNT_W = 5;

  localparam logic LOAD_ACTIVE   = 1'b0;
  localparam logic LOAD_INACTIVE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOADING  = 2'd1,
    ST_SHIFTING = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchronizer with a registered rising-edge pulse.
module sync_edge_detect #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = rise_q;

endmodule

// File: rtl/dip_serializer.sv
// DIP/switch serial transmitter: level-loaded parallel word shifted out MSB first on PSCLK rises.
module dip_serializer
  import dip_serializer_pkg::*;
#(
  parameter int unsigned WIDTH       = 21,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        LOAD_LEVEL  = LOAD_ACTIVE
) (
  input  logic               i_CLK,
  input  logic               i_RESET_n,
  input  logic               i_PSCLK,
  input  logic               i_DIPLatch,
  input  logic [WIDTH-1:0]   i_Word,
  input  logic               i_SerIn,
  output logic               o_DIPData,
  output logic [COUNT_W-1:0] o_BitCount,
  output logic               o_FrameDone,
  output logic               o_Overrun
);

  localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(WIDTH);

  logic             psclk_rise;
  logic             latch_lvl;
  logic             latch_rise_unused;
  logic             load;
  logic [WIDTH-1:0] shift_q;
  logic [COUNT_W-1:0] count_q;
  logic             frame_done_q;
  logic             overrun_q;
  state_e           state_q;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_psclk_sync (
    .clk_i   (i_CLK),
    .rst_ni  (i_RESET_n),
    .d_i     (i_PSCLK),
    .level_o (),
    .rise_o  (psclk_rise)
  );

  // Latch synchronizer resets to the inactive level so leaving reset never looks like a load.
  sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(~LOAD_LEVEL)) u_latch_sync (
    .clk_i   (i_CLK),
    .rst_ni  (i_RESET_n),
    .d_i     (i_DIPLatch),
    .level_o (latch_lvl),
    .rise_o  (latch_rise_unused)
  );

  assign load = (latch_lvl == LOAD_LEVEL);

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      shift_q      <= '0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      frame_done_q <= 1'b0;
      if (load) begin
        shift_q   <= i_Word;
        count_q   <= '0;
        overrun_q <= 1'b0;
        state_q   <= ST_LOADING;
      end else if (state_q != ST_IDLE) begin
        if (state_q == ST_LOADING) begin
          state_q <= ST_SHIFTING;
        end
        if (psclk_rise) begin
          shift_q <= {shift_q[WIDTH-2:0], i_SerIn};
          if (count_q == FULL_CNT) begin
            overrun_q <= 1'b1;
            state_q   <= ST_DONE;
          end else if (count_q == FULL_CNT - 1'b1) begin
            count_q      <= FULL_CNT;
            frame_done_q <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            count_q <= count_q + 1'b1;
            state_q <= ST_SHIFTING;
          end
        end
      end
    end
  end

  assign o_DIPData   = shift_q[WIDTH-1];
  assign o_BitCount  = count_q;
  assign o_FrameDone = frame_done_q;
  assign o_Overrun   = overrun_q;

endmodule

// File: tb/tb_dip_serializer.sv
// Randomized bench for dip_serializer against a frame-level reference model.
module tb_dip_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psclk;
  logic        latch;
  logic [20:0] word;
  logic        serin;
  logic        dip_data;
  logic [4:0]  bit_count;
  logic        frame_done;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  logic [20:0] m_reg;
  int          m_cnt;
  bit          m_ov;
  bit          m_loaded;
  bit          m_latch;
  int          fd_exp = 0;
  int          fd_seen = 0;

  dip_serializer #(.WIDTH(21), .SYNC_STAGES(2), .LOAD_LEVEL(1'b0)) dut (
    .i_CLK       (clk),
    .i_RESET_n   (rst_n),
    .i_PSCLK     (psclk),
    .i_DIPLatch  (latch),
    .i_Word      (word),
    .i_SerIn     (serin),
    .o_DIPData   (dip_data),
    .o_BitCount  (bit_count),
    .o_FrameDone (frame_done),
    .o_Overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dip"}, {31'd0, dip_data}, {31'd0, m_reg[20]});
    check({tag, ".cnt"}, {27'd0, bit_count}, m_cnt);
    check({tag, ".ovr"}, {31'd0, overrun}, {31'd0, m_ov});
    check({tag, ".fd"}, fd_seen, fd_exp);
  endtask

  function automatic void model_rise(input logic s);
    if (m_loaded && !m_latch) begin
      m_reg = {m_reg[19:0], s};
      if (m_cnt == 21) m_ov = 1'b1;
      else begin
        m_cnt++;
        if (m_cnt == 21) fd_exp++;
      end
    end
  endfunction

  function automatic void model_load(input logic [20:0] w);
    m_reg = w; m_cnt = 0; m_ov = 1'b0; m_loaded = 1'b1; m_latch = 1'b1;
  endfunction

  task automatic load_begin(input logic [20:0] w);
    @(negedge clk);
    word = w; latch = 1'b0;
    repeat (6) @(negedge clk);
    model_load(w);
  endtask

  task automatic load_end();
    latch = 1'b1; m_latch = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse(input logic s);
    serin = s; psclk = 1'b1;
    repeat (5) @(negedge clk);
    psclk = 1'b0;
    repeat (5) @(negedge clk);
    model_rise(s);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; psclk = 1'b0; latch = 1'b1; word = '0; serin = 1'b0;
    m_reg = '0; m_cnt = 0; m_ov = 1'b0; m_loaded = 1'b0; m_latch = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Idle: PSCLK edges before any load are ignored
    word = 21'h1FFFFF;
    repeat (3) pulse(1'b1);
    check_all("idle");

    // Case 1/2: full frame, then overrun
    load_begin(21'h1A5A5);
    load_end();
    check_all("c1.load");
    for (int i = 0; i < 21; i++) begin
      pulse(1'b0);
      check_all($sformatf("c1.b%0d", i));
    end
    check("c1.fd_once", fd_seen, 1 + 0 * fd_exp);
    pulse(1'b1);
    pulse(1'b1);
    check_all("c2.over");
    check("c2.ovr_set", {31'd0, overrun}, 32'd1);
    load_begin(21'h0);
    check_all("c2.reload");
    load_end();

    // Case 3: latch held while PSCLK toggles and word changes
    load_begin(21'h00001);
    for (int i = 0; i < 5; i++) pulse(1'b1);
    check_all("c3.a");
    word = 21'h10000; m_reg = word;
    repeat (4) @(negedge clk);
    check_all("c3.b");
    word = 21'h100000; m_reg = word;
    repeat (4) @(negedge clk);
    check_all("c3.c");
    load_end();
    word = 21'h0;
    repeat (4) @(negedge clk);
    check_all("c3.word_ignored");

    // Case 4: abort mid-frame then zero frame
    load_begin(21'h1FFFFF);
    load_end();
    for (int i = 0; i < 7; i++) pulse(1'b0);
    check_all("c4.mid");
    load_begin(21'h000000);
    load_end();
    check_all("c4.reload");
    for (int i = 0; i < 21; i++) pulse(1'b0);
    check_all("c4.zeros");

    // Case 5: latch and PSCLK rise together
    load_begin(21'h155555);
    load_end();
    pulse(1'b1);
    @(negedge clk);
    word = 21'h0AAAAA; latch = 1'b0; psclk = 1'b1; serin = 1'b1;
    repeat (5) @(negedge clk);
    psclk = 1'b0;
    repeat (5) @(negedge clk);
    model_load(21'h0AAAAA);
    check_all("c5.same");
    load_end();

    // Latency: pin rise to data change
    load_begin(21'h100000);
    load_end();
    @(negedge clk);
    serin = 1'b0; psclk = 1'b1; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (dip_data !== 1'b1) begin lat = i; break; end
    end
    check("latency", lat, 4);
    @(negedge clk);
    psclk = 1'b0;
    repeat (5) @(negedge clk);
    model_rise(1'b0);
    check_all("latency.after");

    // Case 6: async reset mid-frame
    load_begin(21'h1FFFFF);
    load_end();
    for (int i = 0; i < 10; i++) pulse(1'b1);
    check_all("c6.pre");
    #2 rst_n = 1'b0;
    #1;
    m_reg = '0; m_cnt = 0; m_ov = 1'b0; m_loaded = 1'b0; m_latch = 1'b0;
    check_all("c6.async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) pulse(1'b1);
    check_all("c6.idle");

    // Randomized frames
    for (int f = 0; f < 10; f++) begin
      int n;
      load_begin(21'($urandom));
      load_end();
      check_all($sformatf("rnd%0d.load", f));
      n = $urandom_range(0, 25);
      for (int i = 0; i < n; i++) begin
        pulse(1'($urandom));
        check_all($sformatf("rnd%0d.b%0d", f, i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
